// File: rtl/e_mdu_pkg.sv
// mdu_pkg: shared MDU op encoding and default latencies for the decoder, hazard unit and e_mdu.
//  The MADD/MSUB codes always exist; they only act when MDU_MADD_EN is defined.
package mdu_pkg;
  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    DIV      = 4'd3,
    DIVU     = 4'd4,
    MFHI     = 4'd5,
    MFLO     = 4'd6,
    MTHI     = 4'd7,
    MTLO     = 4'd8,
    MADD     = 4'd9,
    MADDU    = 4'd10,
    MSUB     = 4'd11,
    MSUBU    = 4'd12
  } mdu_op_e;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
endpackage

// File: rtl/e_mdu_if.sv
// e_mdu_if: EX-stage MDU bundle between the pipeline (master) and the MDU (slave).
//  op/rs/rt/req  pipeline -> MDU : decoded op, forwarded operands, exception cancel
//  busy/hold     MDU -> hazard   : op in flight / op in flight or starting
//  hi/lo/rd_data MDU -> pipeline : architectural HI/LO and mfhi/mflo read data
interface e_mdu_if;
  import mdu_pkg::*;
  mdu_op_e     op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        req;
  logic        busy;
  logic        hold;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  modport master (output op, rs, rt, req, input busy, hold, hi, lo, rd_data);
  modport slave (input op, rs, rt, req, output busy, hold, hi, lo, rd_data);
endinterface

// File: rtl/e_mdu_calc.sv
// mdu_calc: combinational 64-bit {hi,lo} result of a mult/div (and madd/msub with MDU_MADD_EN).
//  op, rs, rt  in : operation and operands
//  acc         in : current {hi,lo}, present only with MDU_MADD_EN
//  res         out: {hi,lo} to commit
//  wr          out: 0 for a divide by zero, which leaves HI/LO untouched
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
`ifdef MDU_MADD_EN
  input  logic [63:0] acc,
`endif
  output logic [63:0] res,
  output logic        wr
);
  logic [63:0] prod_s, prod_u, ext;
  logic [31:0] dvs, quo_u, rem_u;
  logic signed [31:0] quo_s, rem_s;
  logic ovf;
  always_comb begin
    prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u = {32'd0, rs} * {32'd0, rt};
    // a unit divisor yields the required 0x80000000/-1 result and keeps /0 out of the datapath
    ovf = rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF;
    dvs = (rt == 32'd0 || ovf) ? 32'd1 : rt;
    quo_s = $signed(rs) / $signed(dvs);
    rem_s = $signed(rs) % $signed(dvs);
    quo_u = rs / dvs;
    rem_u = rs % dvs;
`ifdef MDU_MADD_EN
    ext = op == MADD  ? acc + prod_s :
          op == MADDU ? acc + prod_u :
          op == MSUB  ? acc - prod_s :
          op == MSUBU ? acc - prod_u : 64'd0;
`else
    ext = 64'd0;
`endif
    res = op == MULT  ? prod_s :
          op == MULTU ? prod_u :
          op == DIV   ? {rem_s, quo_s} :
          op == DIVU  ? {rem_u, quo_u} : ext;
    wr = !((op == DIV || op == DIVU) && rt == 32'd0);
  end
endmodule

// File: rtl/e_mdu.sv
// e_mdu: EX-stage multiply/divide unit owning HI/LO with a busy counter for multi-cycle ops.
//  clk, reset  : clock, synchronous active-high reset
//  m (slave)   : op/rs/rt/req in; busy/hold/hi/lo/rd_data out
//  MULT_LAT/DIV_LAT : busy cycles after an accepted mult / div
//  MDU_MADD_EN : when defined, adds MADD/MADDU/MSUB/MSUBU; otherwise those codes act as MDU_NONE
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input logic clk,
  input logic reset,
  e_mdu_if.slave m
);
  localparam int CW = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);
  logic [CW-1:0] cnt;
  logic [31:0] hi_q, lo_q;
  logic [63:0] res_q, calc_res;
  logic res_wr, calc_wr, is_mul, is_div, start_acc;
  mdu_calc u_calc (
    .op (m.op),
    .rs (m.rs),
    .rt (m.rt),
`ifdef MDU_MADD_EN
    .acc({hi_q, lo_q}),
`endif
    .res(calc_res),
    .wr (calc_wr)
  );
  always_comb begin
    is_mul = m.op == MULT || m.op == MULTU
`ifdef MDU_MADD_EN
      || m.op == MADD || m.op == MADDU || m.op == MSUB || m.op == MSUBU
`endif
      ;
    is_div = m.op == DIV || m.op == DIVU;
    start_acc = (is_mul || is_div) && cnt == '0 && !m.req;
  end
  assign m.busy = cnt != '0;
  assign m.hold = start_acc || m.busy;
  assign m.hi = hi_q;
  assign m.lo = lo_q;
  assign m.rd_data = m.op == MFHI ? hi_q : m.op == MFLO ? lo_q : 32'd0;
  // an in-flight op always finishes, so req and new ops are only looked at while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hi_q <= '0;
      lo_q <= '0;
      res_q <= '0;
      res_wr <= 1'b0;
    end else if (m.busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1) && res_wr) {hi_q, lo_q} <= res_q;
    end else if (start_acc) begin
      res_q <= calc_res;
      res_wr <= calc_wr;
      cnt <= is_mul ? CW'(MULT_LAT) : CW'(DIV_LAT);
    end else if (!m.req) begin
      if (m.op == MTHI) hi_q <= m.rs;
      if (m.op == MTLO) lo_q <= m.rs;
    end
  end
endmodule
